seg_scan_ctrl: RTL and testbench
================================

Name: seg_scan_ctrl

Overview:
Scan scheduler and configuration front-end for the 8-digit multiplexed seven-segment display.
- Time-multiplexes the eight anodes and selects the 4-bit digit nibble for the active slot.
- Applies per-digit enable, decimal-point mask, leading-zero blanking and PWM brightness.
- Takes display updates over a valid/ready handshake and commits them only on frame boundaries, so the display never tears.
- Outputs feed the team's hex-to-cathode decoder and the board pins.

Parameters:
DIV_W, 20, width of slot-period counter and div_cfg
RESET_DIV, 12500, slot period (clocks) used from reset until the first slot boundary

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
enable  in  1  1 = scanning; 0 = all anodes off, counters frozen
div_cfg  in  DIV_W  clocks per digit slot; 0 is treated as 1
bright  in  4  PWM duty: anode lit (bright+1)/16 of the time
lz_blank  in  1  1 = blank leading zero digits
upd_valid  in  1  update request
upd_ready  out  1  update accepted when valid&ready
upd_number  in  32  nibble k = digit for slot k (slot 0 = bits 3:0)
upd_dp_mask  in  8  bit k = 1 lights DP on slot k
upd_en_mask  in  8  bit k = 1 enables slot k
anodes  out  8  active-low digit selects, bit k = slot k
digit  out  4  nibble for the active slot
dp_n  out  1  active-low decimal point
frame_start  out  1  one-cycle pulse when slot wraps 7->0

Behaviour:
- State registers:
  - slot[2:0]
  - tc[DIV_W-1:0] (slot timer)
  - per[DIV_W-1:0] (latched period)
  - pwm[3:0]
  - active regs act_num / act_dp / act_en
  - pending regs pend_* plus pend_full
- Reset (async, reset=0):
  - slot=0, tc=0, per=RESET_DIV, pwm=0.
  - act_num=0, act_dp=0, act_en=8'hFF, pend_full=0.
  - anodes=8'hFF, digit=0, dp_n=1, frame_start=0, upd_ready=1.
  - Reset asserted mid-frame forces these values immediately. No pending update survives.
- All outputs are registered: no combinational path from any input to any output.
- Slot timing:
  - tc increments each enabled clock.
  - When tc==per-1: tc<=0, slot<=slot+1 (wraps 7->0), and per<=max(div_cfg,1).
  - div_cfg is therefore only sampled at slot boundaries.
- pwm increments every enabled clock and wraps 15->0. It is independent of tc.
- Frame commit:
  - On the boundary where slot goes 7->0: if pend_full, act_*<=pend_*, pend_full<=0.
  - frame_start=1 on the cycle slot first equals 0 after the wrap. It does not pulse on the first frame after reset.
- Handshake:
  - upd_ready = ~pend_full.
  - On valid&ready, pend_* <= upd_* and pend_full<=1.
  - If acceptance and commit fall in the same cycle, the commit empties the pending register and the new data is stored. upd_ready stays 0 that cycle. The next frame commits the new data.
  - While ready=0, upd_* is ignored and the requester holds valid.
- Leading-zero blank, computed from act_num:
  - With lz_blank=1, slot k (k>=1) is blanked when nibbles k..7 are all zero.
  - Slot 0 is never blanked.
- Output register update, each clock, from registered state:
  - lit = enable & act_en[slot] & ~blank[slot] & (pwm <= bright).
  - anodes = lit ? ~(1<<slot) : 8'hFF.
  - digit = act_num[4*slot+3 -: 4].
  - dp_n = ~(lit & act_dp[slot]).
  - Outputs therefore lag state by one clock.
- enable=0:
  - tc, slot and pwm hold; handshake continues.
  - Commit occurs only at the enabled 7->0 boundary.
  - Outputs go dark on the following clock.

Test Plan:
- Reset, then upd number=0x76543210, en=FF, dp=00, div_cfg=4, bright=15. After the first commit -> anodes step FE,FD,FB,...,7F, each held 4 clocks; digit=slot; frame_start period = 32 clocks.
- Second update 0xAAAAAAAA issued while slot=3 -> accepted. upd_ready stays low until slot wraps to 0. A third request during that window is not accepted. digit stays 4,5,6,7 then shows A from slot 0.
- number=0x00000050, lz_blank=1 -> anodes=8'hFF during slots 7..2; slot1 shows digit 5; slot0 shows digit 0 lit. lz_blank=0 -> all eight lit.
- bright=3, div_cfg=32 -> within each slot the anode is low exactly 4 of every 16 clocks (pwm 0..3). bright=15 -> continuously low.
- en_mask=8'h0F, dp_mask=8'h01 -> slots 4-7 dark; dp_n=0 only while slot 0 lit.
- div_cfg=0 -> slot advances every clock after the next boundary. Asserting reset mid-frame -> anodes=8'hFF and upd_ready=1 without waiting for a clock edge. After release, act_num=0 and slot=0.

Source files
------------

// File: rtl/seg_scan_ctrl_if.sv
// Display-update handshake between a requester and the scan controller.
interface seg_scan_ctrl_if;
  logic        valid;
  logic        ready;
  logic [31:0] number;
  logic [7:0]  dp_mask;
  logic [7:0]  en_mask;

  modport master (
    output valid,
    output number,
    output dp_mask,
    output en_mask,
    input  ready
  );

  modport slave (
    input  valid,
    input  number,
    input  dp_mask,
    input  en_mask,
    output ready
  );
endinterface

// File: rtl/seg_scan_ctrl.sv
// Eight-digit seven-segment scan scheduler: slot timing, PWM dimming,
// leading-zero blanking and tear-free update commit on frame boundaries.
module seg_scan_ctrl #(
  parameter int unsigned DIV_W     = 20,
  parameter int unsigned RESET_DIV = 12500
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [DIV_W-1:0] div_cfg,
  input  logic [3:0]       bright,
  input  logic             lz_blank,
  seg_scan_ctrl_if.slave   upd,
  output logic [7:0]       anodes,
  output logic [3:0]       digit,
  output logic             dp_n,
  output logic             frame_start
);

  localparam int unsigned SLOTS  = 8;
  localparam int unsigned NIB_W  = 4;
  localparam int unsigned NUM_W  = SLOTS * NIB_W;
  localparam int unsigned SLOT_W = 3;
  localparam int unsigned PWM_W  = 4;

  // Architectural state
  logic [SLOT_W-1:0] slot;
  logic [DIV_W-1:0]  tc;
  logic [DIV_W-1:0]  per;
  logic [PWM_W-1:0]  pwm;
  logic [NUM_W-1:0]  act_num;
  logic [SLOTS-1:0]  act_dp;
  logic [SLOTS-1:0]  act_en;
  logic [NUM_W-1:0]  pend_num;
  logic [SLOTS-1:0]  pend_dp;
  logic [SLOTS-1:0]  pend_en;
  logic              pend_full;
  logic              ready_q;

  // Next-state values
  logic [SLOT_W-1:0] slot_nx;
  logic [DIV_W-1:0]  tc_nx;
  logic [DIV_W-1:0]  per_nx;
  logic [PWM_W-1:0]  pwm_nx;
  logic [NUM_W-1:0]  act_num_nx;
  logic [SLOTS-1:0]  act_dp_nx;
  logic [SLOTS-1:0]  act_en_nx;
  logic [NUM_W-1:0]  pend_num_nx;
  logic [SLOTS-1:0]  pend_dp_nx;
  logic [SLOTS-1:0]  pend_en_nx;
  logic              pend_full_nx;

  // Output next values
  logic [7:0]        anodes_nx;
  logic [3:0]        digit_nx;
  logic              dp_n_nx;
  logic              frame_start_nx;

  // Decode helpers
  logic              slot_end;
  logic              wrap;
  logic              accept;
  logic              commit;
  logic [SLOTS-1:0]  blank;
  logic              upper_zero;
  logic              lit;

  assign upd.ready = ready_q;

  // Slot boundary, frame wrap and handshake events
  always_comb begin
    slot_end = enable && (tc == (per - DIV_W'(1)));
    wrap     = slot_end && (slot == SLOT_W'(SLOTS - 1));
    accept   = upd.valid && !pend_full;
    commit   = wrap && pend_full;
  end

  // Slot timer, slot counter, period latch and PWM phase
  always_comb begin
    slot_nx = slot;
    tc_nx   = tc;
    per_nx  = per;
    pwm_nx  = pwm;
    if (enable) begin
      pwm_nx = pwm + PWM_W'(1);
      if (slot_end) begin
        tc_nx   = '0;
        slot_nx = slot + SLOT_W'(1);
        per_nx  = (div_cfg == '0) ? DIV_W'(1) : div_cfg;
      end else begin
        tc_nx = tc + DIV_W'(1);
      end
    end
  end

  // Pending/active update registers; commit drains before a new accept fills
  always_comb begin
    act_num_nx   = act_num;
    act_dp_nx    = act_dp;
    act_en_nx    = act_en;
    pend_num_nx  = pend_num;
    pend_dp_nx   = pend_dp;
    pend_en_nx   = pend_en;
    pend_full_nx = pend_full;
    if (commit) begin
      act_num_nx   = pend_num;
      act_dp_nx    = pend_dp;
      act_en_nx    = pend_en;
      pend_full_nx = 1'b0;
    end
    if (accept) begin
      pend_num_nx  = upd.number;
      pend_dp_nx   = upd.dp_mask;
      pend_en_nx   = upd.en_mask;
      pend_full_nx = 1'b1;
    end
  end

  // Leading-zero blanking: slot k blanks when nibbles k..7 are all zero
  always_comb begin
    blank      = '0;
    upper_zero = 1'b1;
    for (int k = SLOTS - 1; k >= 1; k--) begin
      upper_zero = upper_zero && (act_num[k*NIB_W +: NIB_W] == '0);
      blank[k]   = lz_blank && upper_zero;
    end
  end

  // Display drive computed from current state, registered below
  always_comb begin
    lit            = enable && act_en[slot] && !blank[slot] && (pwm <= bright);
    anodes_nx      = lit ? ~(8'(1) << slot) : 8'hFF;
    digit_nx       = act_num[{slot, 2'b00} +: NIB_W];
    dp_n_nx        = !(lit && act_dp[slot]);
    frame_start_nx = wrap;
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      slot        <= '0;
      tc          <= '0;
      per         <= DIV_W'(RESET_DIV);
      pwm         <= '0;
      act_num     <= '0;
      act_dp      <= '0;
      act_en      <= 8'hFF;
      pend_num    <= '0;
      pend_dp     <= '0;
      pend_en     <= '0;
      pend_full   <= 1'b0;
      ready_q     <= 1'b1;
      anodes      <= 8'hFF;
      digit       <= '0;
      dp_n        <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      slot        <= slot_nx;
      tc          <= tc_nx;
      per         <= per_nx;
      pwm         <= pwm_nx;
      act_num     <= act_num_nx;
      act_dp      <= act_dp_nx;
      act_en      <= act_en_nx;
      pend_num    <= pend_num_nx;
      pend_dp     <= pend_dp_nx;
      pend_en     <= pend_en_nx;
      pend_full   <= pend_full_nx;
      ready_q     <= !pend_full_nx;
      anodes      <= anodes_nx;
      digit       <= digit_nx;
      dp_n        <= dp_n_nx;
      frame_start <= frame_start_nx;
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: cycle model feeding a scoreboard queue, plus
// directed scenario tasks with inline checks.
module tb_seg_scan_ctrl;

  localparam int unsigned DIV_W     = 20;
  localparam int unsigned RESET_DIV = 8;

  logic             clk;
  logic             reset;
  logic             enable;
  logic [DIV_W-1:0] div_cfg;
  logic [3:0]       bright;
  logic             lz_blank;
  logic [7:0]       anodes;
  logic [3:0]       digit;
  logic             dp_n;
  logic             frame_start;

  seg_scan_ctrl_if upd_if();

  seg_scan_ctrl #(.DIV_W(DIV_W), .RESET_DIV(RESET_DIV)) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .div_cfg     (div_cfg),
    .bright      (bright),
    .lz_blank    (lz_blank),
    .upd         (upd_if),
    .anodes      (anodes),
    .digit       (digit),
    .dp_n        (dp_n),
    .frame_start (frame_start)
  );

  int n_checks = 0;
  int n_fail   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] an;
    logic [3:0] dg;
    logic       dp;
    logic       fs;
    logic       rdy;
  } exp_t;

  exp_t exp_q[$];

  // Reference model state
  int          m_slot, m_tc, m_per, m_pwm;
  logic [31:0] m_num, m_pnum;
  logic [7:0]  m_dp, m_en, m_pdp, m_pen;
  bit          m_pfull, m_acc, m_zero, m_lit;
  exp_t        m_e;

  // Cycle model: predicts the registered outputs produced by each edge
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_slot = 0; m_tc = 0; m_per = RESET_DIV; m_pwm = 0;
      m_num = '0; m_dp = '0; m_en = 8'hFF; m_pfull = 0;
      m_pnum = '0; m_pdp = '0; m_pen = '0;
      exp_q.delete();
    end else begin
      m_zero = ((m_num >> (4 * m_slot)) == 32'd0);
      m_lit  = enable && m_en[m_slot] && !(lz_blank && (m_slot != 0) && m_zero)
               && (m_pwm <= int'(bright));
      m_e.an = m_lit ? 8'(~(8'h01 << m_slot)) : 8'hFF;
      m_e.dg = 4'((m_num >> (4 * m_slot)) & 32'hF);
      m_e.dp = !(m_lit && m_dp[m_slot]);
      m_e.fs = 1'b0;
      m_acc  = upd_if.valid && !m_pfull;
      if (enable) begin
        m_pwm = (m_pwm + 1) % 16;
        if (m_tc == m_per - 1) begin
          m_tc  = 0;
          m_per = (div_cfg == '0) ? 1 : int'(div_cfg);
          if (m_slot == 7) begin
            m_e.fs = 1'b1;
            if (m_pfull) begin
              m_num = m_pnum; m_dp = m_pdp; m_en = m_pen; m_pfull = 0;
            end
          end
          m_slot = (m_slot + 1) % 8;
        end else begin
          m_tc = m_tc + 1;
        end
      end
      if (m_acc) begin
        m_pnum = upd_if.number; m_pdp = upd_if.dp_mask; m_pen = upd_if.en_mask;
        m_pfull = 1;
      end
      m_e.rdy = !m_pfull;
      exp_q.push_back(m_e);
    end
  end

  // Scoreboard: compare each predicted output set on the falling edge
  always @(negedge clk) begin
    exp_t e;
    if (reset === 1'b1 && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks += 5;
      if (anodes !== e.an) begin
        n_fail++; $display("FAIL sb_anodes t=%0t got %h want %h", $time, anodes, e.an);
      end
      if (digit !== e.dg) begin
        n_fail++; $display("FAIL sb_digit t=%0t got %h want %h", $time, digit, e.dg);
      end
      if (dp_n !== e.dp) begin
        n_fail++; $display("FAIL sb_dp_n t=%0t got %b want %b", $time, dp_n, e.dp);
      end
      if (frame_start !== e.fs) begin
        n_fail++; $display("FAIL sb_frame_start t=%0t got %b want %b", $time, frame_start, e.fs);
      end
      if (upd_if.ready !== e.rdy) begin
        n_fail++; $display("FAIL sb_ready t=%0t got %b want %b", $time, upd_if.ready, e.rdy);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] num, input logic [7:0] dp, input logic [7:0] en);
    logic r;
    bit   done;
    done = 0;
    upd_if.valid = 1'b1; upd_if.number = num; upd_if.dp_mask = dp; upd_if.en_mask = en;
    for (int i = 0; i < 3000 && !done; i++) begin
      r = upd_if.ready;
      tick();
      if (r === 1'b1) done = 1;
    end
    upd_if.valid = 1'b0;
    if (!done) begin
      n_checks++; n_fail++;
      $display("FAIL send_timeout got no ready want accept of %h", num);
    end
  endtask

  task automatic wait_fs();
    bit seen;
    seen = 0;
    for (int i = 0; i < 3000 && !seen; i++) begin
      tick();
      if (frame_start === 1'b1) seen = 1;
    end
    if (!seen) begin
      n_checks++; n_fail++;
      $display("FAIL frame_start_timeout got none want pulse");
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    enable = 1'b1; div_cfg = DIV_W'(4); bright = 4'd15; lz_blank = 1'b0;
    upd_if.valid = 1'b0; upd_if.number = '0; upd_if.dp_mask = '0; upd_if.en_mask = '0;
    #1 reset = 1'b0;
    #20;
    n_checks += 5;
    if (anodes !== 8'hFF) begin n_fail++; $display("FAIL reset_anodes got %h want ff", anodes); end
    if (digit !== 4'h0) begin n_fail++; $display("FAIL reset_digit got %h want 0", digit); end
    if (dp_n !== 1'b1) begin n_fail++; $display("FAIL reset_dp_n got %b want 1", dp_n); end
    if (frame_start !== 1'b0) begin n_fail++; $display("FAIL reset_fs got %b want 0", frame_start); end
    if (upd_if.ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b want 1", upd_if.ready); end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_scan();
    logic [7:0] ea;
    send(32'h7654_3210, 8'h00, 8'hFF);
    wait_fs();
    for (int i = 0; i < 32; i++) begin
      tick();
      ea = 8'(~(8'h01 << (i / 4)));
      n_checks += 2;
      if (anodes !== ea) begin n_fail++; $display("FAIL scan_anodes i=%0d got %h want %h", i, anodes, ea); end
      if (digit !== 4'(i / 4)) begin n_fail++; $display("FAIL scan_digit i=%0d got %h want %h", i, digit, 4'(i / 4)); end
    end
    n_checks++;
    if (frame_start !== 1'b1) begin n_fail++; $display("FAIL scan_period got %b want 1 after 32 clocks", frame_start); end
  endtask

  task automatic test_back_to_back();
    repeat (12) tick();
    send(32'hAAAA_AAAA, 8'h00, 8'hFF);
    n_checks++;
    if (upd_if.ready !== 1'b0) begin n_fail++; $display("FAIL b2b_ready_low got %b want 0", upd_if.ready); end
    upd_if.valid = 1'b1; upd_if.number = 32'h1111_1111;
    for (int i = 0; i < 8; i++) begin
      tick();
      n_checks++;
      if (upd_if.ready !== 1'b0) begin n_fail++; $display("FAIL b2b_ready_hold i=%0d got %b want 0", i, upd_if.ready); end
    end
    upd_if.valid = 1'b0;
    wait_fs();
    n_checks++;
    if (upd_if.ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_after_commit got %b want 1", upd_if.ready); end
    tick();
    n_checks += 2;
    if (digit !== 4'hA) begin n_fail++; $display("FAIL b2b_digit got %h want a", digit); end
    if (anodes !== 8'hFE) begin n_fail++; $display("FAIL b2b_anodes got %h want fe", anodes); end
    wait_fs();
    tick();
    n_checks++;
    if (digit !== 4'hA) begin n_fail++; $display("FAIL b2b_third_rejected got %h want a", digit); end
  endtask

  task automatic test_lz_blank();
    logic [7:0] ea;
    logic [3:0] ed;
    lz_blank = 1'b1;
    send(32'h0000_0050, 8'h00, 8'hFF);
    wait_fs();
    for (int i = 0; i < 32; i++) begin
      tick();
      ea = ((i / 4) <= 1) ? 8'(~(8'h01 << (i / 4))) : 8'hFF;
      ed = ((i / 4) == 1) ? 4'h5 : 4'h0;
      n_checks += 2;
      if (anodes !== ea) begin n_fail++; $display("FAIL lz_on_anodes i=%0d got %h want %h", i, anodes, ea); end
      if (digit !== ed) begin n_fail++; $display("FAIL lz_on_digit i=%0d got %h want %h", i, digit, ed); end
    end
    lz_blank = 1'b0;
    for (int i = 0; i < 32; i++) begin
      tick();
      ea = 8'(~(8'h01 << (i / 4)));
      n_checks++;
      if (anodes !== ea) begin n_fail++; $display("FAIL lz_off_anodes i=%0d got %h want %h", i, anodes, ea); end
    end
  endtask

  task automatic test_pwm();
    int cnt;
    bright = 4'd3; div_cfg = DIV_W'(32);
    wait_fs();
    wait_fs();
    for (int s = 0; s < 8; s++) begin
      cnt = 0;
      for (int i = 0; i < 32; i++) begin
        tick();
        if (anodes !== 8'hFF) begin
          cnt++;
          n_checks++;
          if (anodes !== 8'(~(8'h01 << s))) begin
            n_fail++; $display("FAIL pwm_anode_sel s=%0d got %h want %h", s, anodes, 8'(~(8'h01 << s)));
          end
        end
      end
      n_checks++;
      if (cnt != 8) begin n_fail++; $display("FAIL pwm_duty3 s=%0d got %0d want 8", s, cnt); end
    end
    bright = 4'd15;
    cnt = 0;
    for (int i = 0; i < 32; i++) begin
      tick();
      if (anodes === 8'hFE) cnt++;
    end
    n_checks++;
    if (cnt != 32) begin n_fail++; $display("FAIL pwm_duty15 got %0d want 32", cnt); end
  endtask

  task automatic test_masks();
    logic [7:0] ea;
    logic       ed;
    div_cfg = DIV_W'(4);
    send(32'h7654_3210, 8'h01, 8'h0F);
    wait_fs();
    for (int i = 0; i < 32; i++) begin
      tick();
      ea = ((i / 4) < 4) ? 8'(~(8'h01 << (i / 4))) : 8'hFF;
      ed = ((i / 4) == 0) ? 1'b0 : 1'b1;
      n_checks += 2;
      if (anodes !== ea) begin n_fail++; $display("FAIL mask_anodes i=%0d got %h want %h", i, anodes, ea); end
      if (dp_n !== ed) begin n_fail++; $display("FAIL mask_dp_n i=%0d got %b want %b", i, dp_n, ed); end
    end
  endtask

  task automatic test_enable();
    int fs_cnt;
    enable = 1'b0;
    tick();
    n_checks++;
    if (anodes !== 8'hFF) begin n_fail++; $display("FAIL en_dark got %h want ff", anodes); end
    send(32'h1234_5678, 8'h00, 8'hFF);
    n_checks++;
    if (upd_if.ready !== 1'b0) begin n_fail++; $display("FAIL en_accept got %b want 0", upd_if.ready); end
    fs_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (frame_start === 1'b1) fs_cnt++;
    end
    n_checks++;
    if (fs_cnt != 0) begin n_fail++; $display("FAIL en_frozen got %0d want 0 frame pulses", fs_cnt); end
    enable = 1'b1;
  endtask

  task automatic test_div_zero();
    div_cfg = '0;
    wait_fs();
    tick();
    n_checks += 2;
    if (anodes !== 8'hFE) begin n_fail++; $display("FAIL div0_anodes got %h want fe", anodes); end
    if (digit !== 4'h8) begin n_fail++; $display("FAIL div0_digit got %h want 8", digit); end
    tick();
    n_checks++;
    if (anodes !== 8'hFD) begin n_fail++; $display("FAIL div0_step got %h want fd", anodes); end
    repeat (2) tick();
    n_checks++;
    if (frame_start !== 1'b0) begin n_fail++; $display("FAIL div0_mid got %b want 0", frame_start); end
    repeat (4) tick();
    n_checks++;
    if (frame_start !== 1'b1) begin n_fail++; $display("FAIL div0_period got %b want 1", frame_start); end
  endtask

  task automatic test_async_reset();
    div_cfg = DIV_W'(4);
    repeat (5) tick();
    send(32'hDEAD_BEEF, 8'hFF, 8'hFF);
    n_checks++;
    if (upd_if.ready !== 1'b0) begin n_fail++; $display("FAIL ar_pending got %b want 0", upd_if.ready); end
    #1 reset = 1'b0;
    #1;
    n_checks += 5;
    if (anodes !== 8'hFF) begin n_fail++; $display("FAIL ar_anodes got %h want ff", anodes); end
    if (upd_if.ready !== 1'b1) begin n_fail++; $display("FAIL ar_ready got %b want 1", upd_if.ready); end
    if (digit !== 4'h0) begin n_fail++; $display("FAIL ar_digit got %h want 0", digit); end
    if (dp_n !== 1'b1) begin n_fail++; $display("FAIL ar_dp_n got %b want 1", dp_n); end
    if (frame_start !== 1'b0) begin n_fail++; $display("FAIL ar_fs got %b want 0", frame_start); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    tick();
    n_checks += 3;
    if (anodes !== 8'hFE) begin n_fail++; $display("FAIL ar_slot0 got %h want fe", anodes); end
    if (digit !== 4'h0) begin n_fail++; $display("FAIL ar_num0 got %h want 0", digit); end
    if (upd_if.ready !== 1'b1) begin n_fail++; $display("FAIL ar_ready_after got %b want 1", upd_if.ready); end
    wait_fs();
    tick();
    n_checks += 2;
    if (digit !== 4'h0) begin n_fail++; $display("FAIL ar_no_pending got %h want 0", digit); end
    if (dp_n !== 1'b1) begin n_fail++; $display("FAIL ar_no_pending_dp got %b want 1", dp_n); end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_back_to_back();
    test_lz_blank();
    test_pwm();
    test_masks();
    test_enable();
    test_div_zero();
    test_async_reset();
    repeat (3) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
